// File: rtl/sram_pkg.sv
// Purpose: shared sweep-state type and word helpers for the dual-port byte-writable SRAM.
// Latency: none (types and pure functions only).
// Backpressure: none.
//
// Contents:
//   sweep_state_e - post-reset clear sweep state (S_INIT, S_READY)
//   be_merge      - byte-wise merge of a new word into an old word under a byte-enable mask
//   clog2         - ceiling log2, used to size address ports from the entry count
package sram_pkg;

   typedef enum logic {
      S_INIT  = 1'b0,
      S_READY = 1'b1
   } sweep_state_e;

   // be_merge works on the widest word any instance may use; callers widen
   // their operands with a size cast and truncate the result the same way.
   localparam int MERGE_MAX_DW = 1024;
   localparam int MERGE_MAX_BE = MERGE_MAX_DW / 8;

   function automatic logic [MERGE_MAX_DW-1:0] be_merge(
      input logic [MERGE_MAX_DW-1:0] old_w,
      input logic [MERGE_MAX_DW-1:0] new_w,
      input logic [MERGE_MAX_BE-1:0] be
   );
      logic [MERGE_MAX_DW-1:0] res;
      res = old_w;
      for (int i = 0; i < MERGE_MAX_BE; i++) begin
         if (be[i]) begin
            res[i*8 +: 8] = new_w[i*8 +: 8];
         end
      end
      return res;
   endfunction

   function automatic int clog2(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) begin
         r++;
      end
      return r;
   endfunction

endpackage

// File: rtl/sram_out_pipe.sv
// Purpose: optional per-port output register stage (read data + valid).
// Latency: 0 cycles when OUT_REG=0, 1 cycle when OUT_REG=1.
// Backpressure: none; a new word may arrive every cycle.
//
// Ports:
//   clk_i, rst_i   clock and asynchronous active-high reset
//   data_i/valid_i stage-1 read data and valid from the array
//   data_o/valid_o port-facing read data and valid
module sram_out_pipe #(
   parameter int DATA_WIDTH = 32,
   parameter int OUT_REG    = 0
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic [DATA_WIDTH-1:0] data_i,
   input  logic                  valid_i,
   output logic [DATA_WIDTH-1:0] data_o,
   output logic                  valid_o
);

   generate
      if (OUT_REG != 0) begin : g_reg
         logic [DATA_WIDTH-1:0] data_q;
         logic                  valid_q;

         // Stage-1 data already holds while the port is idle, so copying it
         // every cycle preserves the hold behaviour one cycle later.
         always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
               data_q  <= '0;
               valid_q <= 1'b0;
            end else begin
               data_q  <= data_i;
               valid_q <= valid_i;
            end
         end

         assign data_o  = data_q;
         assign valid_o = valid_q;
      end else begin : g_pass
         logic unused_clk_rst;
         assign unused_clk_rst = clk_i ^ rst_i;

         assign data_o  = data_i;
         assign valid_o = valid_i;
      end
   endgenerate

endmodule

// File: rtl/sram_dp_be.sv
// Purpose: true dual-port byte-writable RAM with cross-port bypass and post-reset clear sweep.
// Latency: read data/valid 1 cycle after request (2 with OUT_REG=1); writes land on the request edge.
// Backpressure: none; each port accepts one access per cycle once ready_o is high.
//
// Ports:
//   clk_i, rst_i            clock, asynchronous active-high reset
//   ready_o                 high once the clear sweep has finished
//   {a,b}_en_i              access enable
//   {a,b}_we_i  [BE_W]      byte write enables, all zero = read
//   {a,b}_addr_i [AW]       word address
//   {a,b}_data_i            write data
//   {a,b}_data_o            read data (holds when idle; old word on a write)
//   {a,b}_valid_o           one-cycle read-data-valid pulse (reads only)
module sram_dp_be
   import sram_pkg::*;
#(
   parameter int                    DATA_WIDTH    = 32,
   parameter int                    N_ENTRIES     = 1024,
   parameter int                    OUT_REG       = 0,
   parameter int                    INIT_ON_RESET = 1,
   parameter logic [DATA_WIDTH-1:0] INIT_VALUE    = '0,
   localparam int                   BE_W          = DATA_WIDTH / 8,
   localparam int                   AW            = clog2(N_ENTRIES)
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   output logic                  ready_o,

   input  logic                  a_en_i,
   input  logic [BE_W-1:0]       a_we_i,
   input  logic [AW-1:0]         a_addr_i,
   input  logic [DATA_WIDTH-1:0] a_data_i,
   output logic [DATA_WIDTH-1:0] a_data_o,
   output logic                  a_valid_o,

   input  logic                  b_en_i,
   input  logic [BE_W-1:0]       b_we_i,
   input  logic [AW-1:0]         b_addr_i,
   input  logic [DATA_WIDTH-1:0] b_data_i,
   output logic [DATA_WIDTH-1:0] b_data_o,
   output logic                  b_valid_o
);

   // ------------------------------------------------------------------
   // Clear sweep FSM
   // ------------------------------------------------------------------
   sweep_state_e  state_q, state_d;
   logic [AW-1:0] cnt_q, cnt_d;
   logic          arr_rdy;

   assign arr_rdy = (state_q == S_READY);
   assign ready_o = arr_rdy;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      if (state_q == S_INIT) begin
         cnt_d = cnt_q + 1'b1;
         if (cnt_q == AW'(N_ENTRIES - 1)) begin
            state_d = S_READY;
         end
      end
   end

   // ------------------------------------------------------------------
   // Access decode; both ports are ignored until the sweep is done
   // ------------------------------------------------------------------
   logic a_acc, a_rd, a_wr;
   logic b_acc, b_rd, b_wr;
   logic same_addr;

   assign a_acc     = a_en_i & arr_rdy;
   assign a_wr      = a_acc & (|a_we_i);
   assign a_rd      = a_acc & ~(|a_we_i);
   assign b_acc     = b_en_i & arr_rdy;
   assign b_wr      = b_acc & (|b_we_i);
   assign b_rd      = b_acc & ~(|b_we_i);
   assign same_addr = (a_addr_i == b_addr_i);

   // ------------------------------------------------------------------
   // Array body: kept free of reset and bypass logic so it maps to block RAM
   // ------------------------------------------------------------------
   logic [DATA_WIDTH-1:0] mem [N_ENTRIES];
   logic [DATA_WIDTH-1:0] a_rd_q, b_rd_q;

   // Port A's byte writes are issued after port B's, so on a same-address
   // collision port A owns every byte it enables.
   always_ff @(posedge clk_i) begin
      if (state_q == S_INIT) begin
         mem[cnt_q] <= INIT_VALUE;
      end else begin
         for (int i = 0; i < BE_W; i++) begin
            if (b_wr && b_we_i[i]) begin
               mem[b_addr_i][i*8 +: 8] <= b_data_i[i*8 +: 8];
            end
         end
         for (int i = 0; i < BE_W; i++) begin
            if (a_wr && a_we_i[i]) begin
               mem[a_addr_i][i*8 +: 8] <= a_data_i[i*8 +: 8];
            end
         end
      end
   end

   // Read-first: writes also capture the pre-write word.
   always_ff @(posedge clk_i) begin
      if (a_acc) begin
         a_rd_q <= mem[a_addr_i];
      end
      if (b_acc) begin
         b_rd_q <= mem[b_addr_i];
      end
   end

   // ------------------------------------------------------------------
   // Control registers: FSM, valids, cross-port bypass capture
   // ------------------------------------------------------------------
   logic                  a_has_q, b_has_q;     // data register loaded since reset
   logic                  a_vld_q, b_vld_q;
   logic [DATA_WIDTH-1:0] a_byp_dat_q, b_byp_dat_q;
   logic [BE_W-1:0]       a_byp_be_q, b_byp_be_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q     <= (INIT_ON_RESET != 0) ? S_INIT : S_READY;
         cnt_q       <= '0;
         a_has_q     <= 1'b0;
         b_has_q     <= 1'b0;
         a_vld_q     <= 1'b0;
         b_vld_q     <= 1'b0;
         a_byp_dat_q <= '0;
         b_byp_dat_q <= '0;
         a_byp_be_q  <= '0;
         b_byp_be_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         a_vld_q <= a_rd;
         b_vld_q <= b_rd;
         // A reader on the same address as the other port's writer sees the
         // writer's enabled bytes; the mask is cleared otherwise so the merge
         // below passes the stored word straight through.
         if (a_acc) begin
            a_has_q     <= 1'b1;
            a_byp_dat_q <= b_data_i;
            a_byp_be_q  <= (a_rd && b_wr && same_addr) ? b_we_i : '0;
         end
         if (b_acc) begin
            b_has_q     <= 1'b1;
            b_byp_dat_q <= a_data_i;
            b_byp_be_q  <= (b_rd && a_wr && same_addr) ? a_we_i : '0;
         end
      end
   end

   // ------------------------------------------------------------------
   // Stage-1 read data (bypass merge after the RAM output register)
   // ------------------------------------------------------------------
   logic [DATA_WIDTH-1:0] a_s1_dat, b_s1_dat;

   always_comb begin
      a_s1_dat = '0;
      b_s1_dat = '0;
      if (a_has_q) begin
         a_s1_dat = DATA_WIDTH'(be_merge(MERGE_MAX_DW'(a_rd_q),
                                         MERGE_MAX_DW'(a_byp_dat_q),
                                         MERGE_MAX_BE'(a_byp_be_q)));
      end
      if (b_has_q) begin
         b_s1_dat = DATA_WIDTH'(be_merge(MERGE_MAX_DW'(b_rd_q),
                                         MERGE_MAX_DW'(b_byp_dat_q),
                                         MERGE_MAX_BE'(b_byp_be_q)));
      end
   end

   sram_out_pipe #(
      .DATA_WIDTH (DATA_WIDTH),
      .OUT_REG    (OUT_REG)
   ) u_a_pipe (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .data_i  (a_s1_dat),
      .valid_i (a_vld_q),
      .data_o  (a_data_o),
      .valid_o (a_valid_o)
   );

   sram_out_pipe #(
      .DATA_WIDTH (DATA_WIDTH),
      .OUT_REG    (OUT_REG)
   ) u_b_pipe (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .data_i  (b_s1_dat),
      .valid_i (b_vld_q),
      .data_o  (b_data_o),
      .valid_o (b_valid_o)
   );

endmodule

// File: doc/sram_dp_be.md
Name: sram_dp_be

Overview:
- True dual-port, byte-writable on-chip RAM for cache data/tag arrays. Successor to the single-port cache SRAM.
- Adds a second port, per-byte write enables, cross-port collision/bypass rules, an optional output register stage, and a post-reset clear sweep with a ready flag.
- Sits under the I/D-cache controllers; the array body maps to block RAM, and all control logic sits around it.

Parameters:
- DATA_WIDTH, 32, word width in bits; must be a multiple of 8.
- N_ENTRIES, 1024, number of words; must be a power of two and at least 2.
- OUT_REG, 0, 1 adds one output register stage per port (read latency 2).
- INIT_ON_RESET, 1, 1 clears every entry after reset; 0 skips the sweep.
- INIT_VALUE, 0, DATA_WIDTH-bit word written by the sweep.
- Local parameters: BE_W = DATA_WIDTH/8; AW = $clog2(N_ENTRIES).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset; asynchronous, active-high.
- ready_o  out  1  array usable; 0 while the clear sweep runs.
- a_en_i  in  1  port A access enable.
- a_we_i  in  BE_W  port A byte write enables; all zeros means read.
- a_addr_i  in  AW  port A word address.
- a_data_i  in  DATA_WIDTH  port A write data.
- a_data_o  out  DATA_WIDTH  port A read data.
- a_valid_o  out  1  port A read data valid, one-cycle pulse.
- b_en_i, b_we_i, b_addr_i, b_data_i, b_data_o, b_valid_o: same as port A, for port B.

Behaviour:
- Reset values: a/b_data_o = 0, a/b_valid_o = 0, sweep counter = 0.
  - ready_o = 0 if INIT_ON_RESET=1, else 1.
  - State = S_INIT if INIT_ON_RESET=1, else S_READY.
  - Array contents are not reset.
- FSM states:
  - S_INIT: each cycle writes INIT_VALUE to entry cnt, then cnt++. After the write to N_ENTRIES-1, go to S_READY and set ready_o=1 on the next edge.
  - ready_o therefore rises exactly N_ENTRIES cycles after reset release.
  - S_READY: terminal until the next reset.
- During S_INIT, both ports' en_i are ignored: no writes, no valid pulses, data_o holds.
- Reset asserted mid-sweep: FSM and counter return to reset values immediately, and the sweep restarts from entry 0.
- Write (S_READY, en=1, we!=0): for each byte i with we[i]=1, byte i of RAM[addr] takes byte i of data_i on the edge. Other bytes are unchanged.
- Read (en=1, we=0):
  - OUT_REG=0: data_o updates on the edge after the request and valid_o pulses in that same cycle (latency 1).
  - OUT_REG=1: both are delayed one further cycle (latency 2).
- Same-port read-during-write: a write access also loads data_o with the OLD word (read-first), but valid_o stays 0.
- data_o holds its last value when the port is idle.
- Cross-port, same address, same cycle:
  - Both write: per byte, port A wins where a_we[i]=1; port B writes only bytes with a_we[i]=0 and b_we[i]=1.
  - One reads, other writes: the reader returns the word with the writer's enabled bytes merged in (write-through bypass); the remaining bytes are the old data.
  - Both read: both return the same stored word.
- Back-to-back accesses are fully pipelined, one per port per cycle. There is no backpressure.
- Address width is exact (AW bits), so there is no out-of-range handling.

Decomposition:
- Package sram_pkg:
  - sweep state enum {S_INIT, S_READY};
  - function be_merge(old, new, be), returning the byte-wise merged word;
  - function clog2 helper.
- Sub-module sram_out_pipe: per-port optional output stage (data + valid), parameterised by DATA_WIDTH and OUT_REG. Instantiated twice.
- The array and the cross-port bypass compare stay in the top module so synthesis infers block RAM.

Test Plan:
- Sweep with N_ENTRIES=16, INIT_VALUE=32'hA5A5A5A5: release reset, count cycles until ready_o=1 (exactly 16). Read all 16 addresses on port B; each must return 32'hA5A5A5A5.
- Mid-sweep reset: assert rst_i for 1 cycle at sweep cycle 7 -> ready_o stays 0 and rises 16 cycles after the second release. Port A writes attempted during S_INIT must not change contents.
- Byte enables: A writes 32'h11223344 to addr 3 with we=4'b1111, then 32'hAABBCCDD with we=4'b0101 -> a B read of addr 3 returns 32'h11BB33DD, with b_valid_o at latency 1 (OUT_REG=0) or 2 (OUT_REG=1).
- Dual write collision on addr 5: A writes 32'h000000FF with we=4'b0001, B writes 32'hEEEEEEEE with we=4'b1111 in the same cycle -> addr 5 reads 32'hEEEEEEFF.
- Cross-port bypass vs. same-port read-first: addr 9 holds 32'h12345678. Same cycle, A writes 32'hCAFEF00D with we=4'b0011 while B reads addr 9 -> b_data_o = 32'h1234F00D. a_data_o = 32'h12345678 with a_valid_o=0.
- Idle hold: after one read returns 32'h12345678, hold en=0 for 5 cycles -> data_o is unchanged and valid_o stays 0.
